operand_mux_skid: RTL and testbench
===================================

// Module: operand_mux_skid
// PURPOSE
//   Parametrised N:1 operand-select mux for the X stage, registered and followed by a 2-entry
//   skid buffer with valid/ready handshake. A select code is latched with its data, so a stalled
//   downstream never loses or reorders operands. Out-of-range selects are flagged and counted.
//   Sits between the forwarding-select logic and the ALU operand latch; generalises the 3:1 mux.
// PARAMETERS
//   WIDTH    32  operand width in bits
//   NUM_IN   3   number of candidate inputs (>=2); SEL_W = $clog2(NUM_IN) (localparam)
//   CNT_W    8   width of saturating illegal-select counter
//   FILL     0   WIDTH-bit value emitted for an illegal select
// PORTS
//   clk          in   1              rising-edge clock
//   rst_n        in   1              asynchronous active-low reset
//   flush        in   1              synchronous pipeline flush
//   in_valid     in   1              upstream beat valid
//   in_ready     out  1              block can accept a beat this cycle
//   in_data      in   NUM_IN*WIDTH   packed candidates; input k = in_data[k*WIDTH +: WIDTH]
//   in_sel       in   SEL_W          index of selected candidate
//   out_valid    out  1              out_data/out_src valid
//   out_ready    in   1              downstream accepts beat
//   out_data     out  WIDTH          selected operand
//   out_src      out  SEL_W          select code that produced out_data
//   err_illegal  out  1              one-cycle pulse: accepted beat had in_sel >= NUM_IN
//   err_count    out  CNT_W          saturating count of illegal-select beats
// BEHAVIOUR
//   Reset (rst_n=0, async): out_valid=0, out_data=0, out_src=0, err_illegal=0, err_count=0,
//     both entries empty, in_ready=1. Outputs registered; no comb path in_* -> out_*.
//   Accept: in_valid & in_ready. Mux result = in_data[in_sel] if in_sel<NUM_IN, else FILL.
//   Latency: accepted beat appears on out_* the next cycle when buffer empty. Emit: out_valid & out_ready.
//   in_ready = !skid_valid (registered, depends only on state, never on in_valid).
//   States: EMPTY (main=0,skid=0), ONE (main=1,skid=0), FULL (main=1,skid=1).
//     EMPTY: accept -> ONE (load main).
//     ONE: accept&emit -> ONE (main<=new); accept&!emit -> FULL (skid<=new);
//          !accept&emit -> EMPTY; else hold.
//     FULL: in_ready=0; emit -> ONE (main<=skid); else hold.
//   out_* driven from main; held stable while out_valid & !out_ready (AXI-style rule).
//   Order strictly FIFO; no beat dropped or duplicated except by flush.
//   flush=1: next cycle EMPTY, out_valid=0, in_ready=1. Flush overrides a same-cycle accept
//     (beat discarded, not counted, err_illegal=0) and a same-cycle emit (emit still counts downstream).
//   err_illegal pulses the cycle after an accepted illegal beat; err_count +1, saturates at
//     2**CNT_W-1; err_count is not cleared by flush, only by rst_n.
//   rst_n asserted mid-operation: all contents lost immediately, outputs to reset values.
//   NUM_IN power of two: illegal select impossible; err logic constant 0.
// STRUCTURE
//   Shared package fwd_pkg: SEL_W helper function, FILL default, state enum {EMPTY,ONE,FULL}.
//   One sub-module: skid_buffer #(.W(WIDTH+SEL_W)) holding {data,src}; mux + error logic
//   stay in the top level.
// TESTING
//   1 Reset mid-stream with FULL state -> same cycle out_valid=0, err_count=0; in_ready=1.
//   2 NUM_IN=3, in_data={C,B,A}, sel=0,1,2 back-to-back, out_ready=1 -> A,B,C one cycle later, out_src 0,1,2.
//   3 out_ready=0 for 3 cycles while sending A,B,C -> in_ready drops after B; C held upstream;
//     release -> A,B,C emitted in order, no loss.
//   4 sel=3 with NUM_IN=3 -> out_data=FILL(0), out_src=3, err_illegal 1-cycle pulse, err_count=1;
//     CNT_W=2, 5 illegal beats -> err_count=3.
//   5 flush with in_valid & in_ready and FULL buffer -> next cycle out_valid=0, flushed beat never
//     appears, err_count unchanged even if flushed beat was illegal.
//   6 NUM_IN=4, WIDTH=16 random valid/ready stress vs scoreboard -> zero mismatches, zero errors.

Source files
------------

// File: rtl/fwd_pkg.sv
// fwd_pkg: shared definitions for the forwarding / operand-select path.
//   sel_w()       : select-code width for an N:1 mux (at least 1 bit)
//   FILL_DEFAULT  : operand value emitted for an out-of-range select
//   skid_state_e  : occupancy of the 2-entry skid buffer
package fwd_pkg;

  localparam int FILL_DEFAULT = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,   // main=0, skid=0
    ONE   = 2'd1,   // main=1, skid=0
    FULL  = 2'd2    // main=1, skid=1
  } skid_state_e;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// skid_buffer: 2-entry registered valid/ready buffer.
//   clk, rst_n   : clock, async active-low reset
//   flush        : synchronous clear of both entries
//   in_valid/in_ready/in_data    : upstream handshake (in_ready is purely registered)
//   out_valid/out_ready/out_data : downstream handshake, out_data driven from main entry
// The skid entry only fills when main is occupied and stalled, so in_ready
// can be a function of state alone and upstream never sees a comb path.
module skid_buffer
  import fwd_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_e  st_q, st_d;
  logic [W-1:0] main_q, skid_q;
  logic         acc, emit;

  assign in_ready  = (st_q != FULL);
  assign out_valid = (st_q != EMPTY);
  assign out_data  = main_q;
  assign acc       = in_valid & in_ready;
  assign emit      = out_valid & out_ready;

  always_comb begin
    st_d = st_q;
    case (st_q)
      EMPTY:   if (acc) st_d = ONE;
      ONE: begin
        if (acc && !emit)      st_d = FULL;
        else if (!acc && emit) st_d = EMPTY;
      end
      FULL:    if (emit) st_d = ONE;
      default: st_d = EMPTY;
    endcase
    if (flush) st_d = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= EMPTY;
    else        st_q <= st_d;
  end

  // Data moves only on handshakes; a flush leaves the payload regs alone
  // since out_valid=0 already hides them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (!flush) begin
      case (st_q)
        EMPTY: if (acc) main_q <= in_data;
        ONE: begin
          if (acc && emit) main_q <= in_data;
          else if (acc)    skid_q <= in_data;
        end
        FULL: if (emit) main_q <= skid_q;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/operand_mux_skid.sv
// operand_mux_skid: NUM_IN:1 operand select for the X stage, registered
// through a 2-entry skid buffer so a stalled ALU never loses operands.
//   clk, rst_n   : clock, async active-low reset
//   flush        : synchronous pipeline flush (drops buffered and incoming beats)
//   in_valid/in_ready, in_data (NUM_IN packed candidates), in_sel
//   out_valid/out_ready, out_data (selected operand), out_src (its select code)
//   err_illegal  : 1-cycle pulse after an accepted beat with in_sel >= NUM_IN
//   err_count    : saturating illegal-beat count, cleared only by reset
module operand_mux_skid
  import fwd_pkg::*;
#(
  parameter  int               WIDTH  = 32,
  parameter  int               NUM_IN = 3,
  parameter  int               CNT_W  = 8,
  parameter  logic [WIDTH-1:0] FILL   = WIDTH'(FILL_DEFAULT),
  localparam int               SEL_W  = sel_w(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    err_illegal,
  output logic [CNT_W-1:0]        err_count
);

  localparam int BW = WIDTH + SEL_W;

  logic [NUM_IN-1:0][WIDTH-1:0] cand;
  logic [WIDTH-1:0]             mux_data;
  logic [BW-1:0]                buf_out;

  assign cand = in_data;

  always_comb begin
    mux_data = FILL;
    for (int k = 0; k < NUM_IN; k++)
      if (int'(in_sel) == k) mux_data = cand[k];
  end

  // Select code travels with its data so out_src always matches out_data.
  skid_buffer #(.W(BW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({mux_data, in_sel}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (buf_out)
  );

  assign out_data = buf_out[BW-1:SEL_W];
  assign out_src  = buf_out[SEL_W-1:0];

  generate
    if (NUM_IN == (1 << SEL_W)) begin : g_noerr
      // Every code is a valid input; nothing to flag.
      assign err_illegal = 1'b0;
      assign err_count   = '0;
    end else begin : g_err
      logic acc_kept, sel_bad;
      // A flushed beat is discarded before it can be counted.
      assign acc_kept = in_valid & in_ready & ~flush;
      assign sel_bad  = (int'(in_sel) >= NUM_IN);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          err_illegal <= 1'b0;
          err_count   <= '0;
        end else begin
          err_illegal <= acc_kept & sel_bad;
          if (acc_kept && sel_bad && (err_count != '1))
            err_count <= err_count + CNT_W'(1);
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_operand_mux_skid.sv
module tb_operand_mux_skid;

  localparam logic [31:0] A = 32'h1111_000A;
  localparam logic [31:0] B = 32'h2222_000B;
  localparam logic [31:0] C = 32'h3333_000C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT1: NUM_IN=3, WIDTH=32, CNT_W=2
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, err_illegal;
  logic [95:0] in_data;
  logic [1:0]  in_sel, out_src, err_count;
  logic [31:0] out_data;

  // DUT2: NUM_IN=4, WIDTH=16
  logic        flush2, in_valid2, in_ready2, out_valid2, out_ready2, err_illegal2;
  logic [63:0] in_data2;
  logic [1:0]  in_sel2, out_src2;
  logic [7:0]  err_count2;
  logic [15:0] out_data2;

  operand_mux_skid #(.WIDTH(32), .NUM_IN(3), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src), .err_illegal(err_illegal), .err_count(err_count));

  operand_mux_skid #(.WIDTH(16), .NUM_IN(4), .CNT_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .in_sel(in_sel2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_data(out_data2), .out_src(out_src2), .err_illegal(err_illegal2), .err_count(err_count2));

  typedef struct { logic [31:0] d; logic [1:0] s; int c; } exp_t;
  exp_t q1[$];
  exp_t q2[$];
  int   total = 0, bad = 0, cyc = 0;
  bit   check_lat = 1'b0;
  bit   stress_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: pop and compare on every emitted beat
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (q1.size() == 0) chk("dut1 unexpected beat", {32'h0, out_data}, 64'hDEAD);
      else begin
        e = q1.pop_front();
        chk("dut1 data", out_data, e.d);
        chk("dut1 src", out_src, e.s);
        if (check_lat) chk("dut1 latency", cyc - e.c, 1);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid2 && out_ready2) begin
      if (q2.size() == 0) chk("dut2 unexpected beat", {48'h0, out_data2}, 64'hDEAD);
      else begin
        e = q2.pop_front();
        chk("dut2 data", out_data2, e.d);
        chk("dut2 src", out_src2, e.s);
        chk("dut2 err_illegal", err_illegal2, 0);
      end
    end
  end

  task automatic send1(input logic [1:0] s, input logic [31:0] expd);
    exp_t e;
    int   n = 0;
    in_valid = 1'b1; in_data = {C, B, A}; in_sel = s;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) chk("dut1 accept timeout", 0, 1);
    e.d = expd; e.s = s; e.c = cyc;
    @(posedge clk);
    if (in_ready) q1.push_back(e);
    #1 in_valid = 1'b0;
  endtask

  task automatic send2(input logic [63:0] d, input logic [1:0] s, input logic [15:0] expd);
    exp_t e;
    int   n = 0;
    in_valid2 = 1'b1; in_data2 = d; in_sel2 = s;
    @(negedge clk);
    while (!in_ready2 && n < 50) begin @(negedge clk); n++; end
    if (!in_ready2) chk("dut2 accept timeout", 0, 1);
    e.d = {16'h0, expd}; e.s = s; e.c = cyc;
    @(posedge clk);
    if (in_ready2) q2.push_back(e);
    #1 in_valid2 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = 1'b1;
    flush2 = 1'b0; in_valid2 = 1'b0; in_data2 = '0; in_sel2 = '0; out_ready2 = 1'b0;
    #12;
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset out_src", out_src, 0);
    chk("reset err_illegal", err_illegal, 0);
    chk("reset err_count", err_count, 0);
    chk("reset in_ready", in_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // back-to-back A,B,C with one-cycle latency
    check_lat = 1'b1;
    send1(2'd0, A); send1(2'd1, B); send1(2'd2, C);
    repeat (3) @(posedge clk);
    #1 check_lat = 1'b0;
    chk("t2 drained", q1.size(), 0);

    // downstream stall: in_ready drops once A,B are buffered, C waits
    out_ready = 1'b0;
    fork
      begin send1(2'd0, A); send1(2'd1, B); send1(2'd2, C); end
      begin
        repeat (3) @(posedge clk);
        #2;
        chk("t3 in_ready low", in_ready, 0);
        chk("t3 held valid", out_valid, 1);
        chk("t3 held data", out_data, A);
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1 chk("t3 drained", q1.size(), 0);

    // illegal select -> FILL, src=3, pulse and count
    send1(2'd3, 32'h0);
    chk("t4 err_illegal pulse", err_illegal, 1);
    chk("t4 err_count", err_count, 1);
    @(posedge clk); #1;
    chk("t4 err_illegal clears", err_illegal, 0);
    chk("t4 err_count hold", err_count, 1);

    // flush racing an accepted illegal beat
    out_ready = 1'b0;
    send1(2'd0, A);
    in_valid = 1'b1; in_sel = 2'd3; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; q1.delete();
    chk("t5a out_valid", out_valid, 0);
    chk("t5a in_ready", in_ready, 1);
    chk("t5a err_illegal", err_illegal, 0);
    chk("t5a err_count", err_count, 1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;

    // flush with FULL buffer and a same-cycle emit (A still delivered)
    out_ready = 1'b0;
    send1(2'd0, A); send1(2'd1, B);
    chk("t5b full in_ready", in_ready, 0);
    out_ready = 1'b1; flush = 1'b1; in_valid = 1'b1; in_sel = 2'd3;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; q1.delete();
    chk("t5b out_valid", out_valid, 0);
    chk("t5b in_ready", in_ready, 1);
    chk("t5b err_count", err_count, 1);
    repeat (3) @(posedge clk); #1;

    // saturation of the 2-bit counter: 1 -> 2 -> 3 -> 3 ...
    begin
      logic [1:0] cnt_tab [5] = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
      for (int i = 0; i < 5; i++) begin
        send1(2'd3, 32'h0);
        chk($sformatf("t4b err_count[%0d]", i), err_count, cnt_tab[i]);
      end
    end
    repeat (2) @(posedge clk); #1;

    // asynchronous reset while FULL
    out_ready = 1'b0;
    send1(2'd1, B); send1(2'd2, C);
    chk("t1 pre in_ready", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t1 out_valid", out_valid, 0);
    chk("t1 err_count", err_count, 0);
    chk("t1 in_ready", in_ready, 1);
    chk("t1 out_data", out_data, 0);
    q1.delete();
    @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;

    // random valid/ready stress on the 4-input instance
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          logic [15:0] c0, c1, c2, c3, pick;
          logic [1:0]  s;
          c0 = 16'($urandom); c1 = 16'($urandom); c2 = 16'($urandom); c3 = 16'($urandom);
          s = 2'($urandom_range(0, 3));
          case (s)
            2'd0: pick = c0;
            2'd1: pick = c1;
            2'd2: pick = c2;
            default: pick = c3;
          endcase
          send2({c3, c2, c1, c0}, s, pick);
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
        for (int n = 0; n < 200 && q2.size() != 0; n++) @(posedge clk);
        #1 chk("t6 drained", q2.size(), 0);
        chk("t6 err_count", err_count2, 0);
        stress_done = 1'b1;
      end
      begin
        while (!stress_done) begin
          @(posedge clk); #1;
          out_ready2 = ($urandom_range(0, 3) != 0);
        end
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
